// File: rtl/morse_decoder.sv
// Morse key decoder: synchronizer, debouncer, unit timing, element FSM and table lookup.
// Optional word-gap space output is enabled by defining MORSE_WORD_GAP_EN.
module morse_decoder #(
  parameter int TICK_DIV   = 2500000,
  parameter int DEB_LEN    = 50000,
  parameter int DASH_UNITS = 2,
  parameter int CHAR_GAP   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic [4:0] code,
  output logic [2:0] width,
  output logic [5:0] dout,
  output logic       valid,
  output logic       err
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

`ifdef MORSE_WORD_GAP_EN
  localparam bit WORD_GAP = 1'b1;
`else
  localparam bit WORD_GAP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  // ---------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------
  logic          sync1_reg, sync2_reg;
  logic          deb_reg, deb_prev_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          deb_rise, deb_fall, deb_edge;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      deb_reg      <= 1'b0;
      deb_prev_reg <= 1'b0;
      deb_cnt_reg  <= '0;
    end else begin
      sync1_reg    <= key_in;
      sync2_reg    <= sync1_reg;
      deb_prev_reg <= deb_reg;
      // Level follows only after DEB_LEN consecutive cycles of disagreement
      if (sync2_reg == deb_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DW'(DEB_LEN - 1)) begin
        deb_reg     <= sync2_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DW'(1);
      end
    end
  end

  assign deb_rise = deb_reg & ~deb_prev_reg;
  assign deb_fall = ~deb_reg & deb_prev_reg;
  assign deb_edge = deb_rise | deb_fall;

  // ---------------------------------------------------------------
  // Unit timing
  // ---------------------------------------------------------------
  logic [TW-1:0] tick_cnt_reg;
  logic [2:0]    unit_cnt_reg;
  logic          unit_tick, gap_tick, word_tick, is_dash;

  assign unit_tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
      unit_cnt_reg <= 3'd0;
    end else if (deb_edge) begin
      tick_cnt_reg <= '0;
      unit_cnt_reg <= 3'd0;
    end else begin
      tick_cnt_reg <= unit_tick ? '0 : tick_cnt_reg + TW'(1);
      if (unit_tick && unit_cnt_reg != 3'd7)
        unit_cnt_reg <= unit_cnt_reg + 3'd1;
    end
  end

  // Ticks that make the unit count reach the character gap / word gap
  assign gap_tick  = unit_tick && (unit_cnt_reg == 3'(CHAR_GAP - 1));
  assign word_tick = unit_tick && (unit_cnt_reg == 3'd6);
  assign is_dash   = (unit_cnt_reg >= 3'(DASH_UNITS));

  // ---------------------------------------------------------------
  // Character lookup: {element count, pattern} -> character code
  // ---------------------------------------------------------------
  function automatic logic [5:0] lookup(input logic [2:0] w, input logic [4:0] c);
    logic [5:0] r;
    r = 6'd63;
    case ({w, c})
      {3'd5, 5'b11111}: r = 6'd0;
      {3'd5, 5'b11110}: r = 6'd1;
      {3'd5, 5'b11100}: r = 6'd2;
      {3'd5, 5'b11000}: r = 6'd3;
      {3'd5, 5'b10000}: r = 6'd4;
      {3'd5, 5'b00000}: r = 6'd5;
      {3'd5, 5'b00001}: r = 6'd6;
      {3'd5, 5'b00011}: r = 6'd7;
      {3'd5, 5'b00111}: r = 6'd8;
      {3'd5, 5'b01111}: r = 6'd9;
      {3'd2, 5'b00010}: r = 6'd10;  // A
      {3'd4, 5'b00001}: r = 6'd11;
      {3'd4, 5'b00101}: r = 6'd12;
      {3'd3, 5'b00001}: r = 6'd13;
      {3'd1, 5'b00000}: r = 6'd14;
      {3'd4, 5'b00100}: r = 6'd15;
      {3'd3, 5'b00011}: r = 6'd16;
      {3'd4, 5'b00000}: r = 6'd17;
      {3'd2, 5'b00000}: r = 6'd18;
      {3'd4, 5'b01110}: r = 6'd19;
      {3'd3, 5'b00101}: r = 6'd20;
      {3'd4, 5'b00010}: r = 6'd21;
      {3'd2, 5'b00011}: r = 6'd22;
      {3'd2, 5'b00001}: r = 6'd23;
      {3'd3, 5'b00111}: r = 6'd24;
      {3'd4, 5'b00110}: r = 6'd25;
      {3'd4, 5'b01011}: r = 6'd26;
      {3'd3, 5'b00010}: r = 6'd27;
      {3'd3, 5'b00000}: r = 6'd28;
      {3'd1, 5'b00001}: r = 6'd29;
      {3'd3, 5'b00100}: r = 6'd30;
      {3'd4, 5'b01000}: r = 6'd31;
      {3'd3, 5'b00110}: r = 6'd32;
      {3'd4, 5'b01001}: r = 6'd33;
      {3'd4, 5'b01101}: r = 6'd34;
      {3'd4, 5'b00011}: r = 6'd35;  // Z
      default:          r = 6'd63;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------
  // Element buffer and control FSM
  // ---------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [4:0] elem_reg, elem_next;
  logic [2:0] count_reg, count_next;
  logic       ovf_reg, ovf_next;
  logic       pend_reg, pend_next;
  logic       armed_reg, armed_next;
  logic [4:0] code_reg, code_next;
  logic [2:0] width_reg, width_next;
  logic [5:0] dout_reg, dout_next;
  logic       valid_reg, valid_next;
  logic       err_reg, err_next;
  logic       clear_buf, append;
  logic [5:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_elem
      assign elem_next[gi] = clear_buf ? 1'b0 :
                             (append && count_reg == 3'(gi)) ? is_dash : elem_reg[gi];
    end
  endgenerate

  assign match = lookup(count_reg, elem_reg);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    pend_next  = pend_reg;
    armed_next = armed_reg;
    code_next  = code_reg;
    width_next = width_reg;
    dout_next  = dout_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    clear_buf  = 1'b0;
    append     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (deb_rise) begin
          state_next = MARK;
          clear_buf  = 1'b1;
          count_next = 3'd0;
          ovf_next   = 1'b0;
          armed_next = 1'b0;
        end else if (WORD_GAP && armed_reg && word_tick) begin
          armed_next = 1'b0;
          code_next  = 5'd0;
          width_next = 3'd0;
          dout_next  = 6'd36;
          valid_next = 1'b1;
        end
      end
      MARK: begin
        if (deb_fall) begin
          state_next = SPACE;
          if (count_reg == 3'd5) begin
            ovf_next = 1'b1;
          end else begin
            append     = 1'b1;
            count_next = count_reg + 3'd1;
          end
        end
      end
      SPACE: begin
        // The gap tick wins over a simultaneous press; the press is replayed after EMIT
        if (gap_tick) begin
          state_next = EMIT;
          pend_next  = deb_rise;
          armed_next = 1'b1;
          code_next  = elem_reg;
          width_next = count_reg;
          dout_next  = ovf_reg ? 6'd63 : match;
          err_next   = ovf_reg || (match == 6'd63);
          valid_next = 1'b1;
        end else if (deb_rise) begin
          state_next = MARK;
        end
      end
      EMIT: begin
        pend_next = 1'b0;
        if (pend_reg || deb_rise) begin
          state_next = MARK;
          clear_buf  = 1'b1;
          count_next = 3'd0;
          ovf_next   = 1'b0;
          armed_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      elem_reg  <= 5'd0;
      count_reg <= 3'd0;
      ovf_reg   <= 1'b0;
      pend_reg  <= 1'b0;
      armed_reg <= 1'b0;
      code_reg  <= 5'd0;
      width_reg <= 3'd0;
      dout_reg  <= 6'd0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      elem_reg  <= elem_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      pend_reg  <= pend_next;
      armed_reg <= armed_next;
      code_reg  <= code_next;
      width_reg <= width_next;
      dout_reg  <= dout_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  assign code  = code_reg;
  assign width = width_reg;
  assign dout  = dout_reg;
  assign valid = valid_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed plus randomized bench for morse_decoder; expectations come from a
// string-based Morse table model. Honors MORSE_WORD_GAP_EN when defined.
module tb_morse_decoder;

  localparam int TICK_DIV   = 4;
  localparam int DEB_LEN    = 2;
  localparam int DASH_UNITS = 2;
  localparam int CHAR_GAP   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_in = 1'b0;
  logic [4:0] code;
  logic [2:0] width;
  logic [5:0] dout;
  logic       valid;
  logic       err;

  morse_decoder #(
    .TICK_DIV(TICK_DIV), .DEB_LEN(DEB_LEN), .DASH_UNITS(DASH_UNITS), .CHAR_GAP(CHAR_GAP)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in),
    .code(code), .width(width), .dout(dout), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] dout;
    logic [4:0] code;
    logic [2:0] width;
    logic       err;
  } ev_t;

  ev_t   evq[$];
  int    checks = 0;
  int    failures = 0;
  logic  valid_prev = 1'b0;
  string morse_tab[36];

  // Collect every emitted character; err must ride on valid, valid lasts one cycle
  always @(negedge clk) begin
    ev_t ev;
    if (valid === 1'b1) begin
      ev.dout = dout; ev.code = code; ev.width = width; ev.err = err;
      evq.push_back(ev);
      checks++;
      assert (valid_prev !== 1'b1) else begin
        failures++;
        $error("FAIL valid_one_cycle observed=%0b expected=0", valid_prev);
      end
    end
    if (err === 1'b1) begin
      checks++;
      assert (valid === 1'b1) else begin
        failures++;
        $error("FAIL err_with_valid observed=%0b expected=1", valid);
      end
    end
    valid_prev = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: element string -> expected outputs
  task automatic model(input string p, output logic [5:0] d, output logic [4:0] c,
                       output logic [2:0] w, output logic e);
    c = 5'd0;
    for (int i = 0; i < p.len() && i < 5; i++)
      if (p[i] == "-") c[i] = 1'b1;
    w = (p.len() > 5) ? 3'd5 : 3'(p.len());
    d = 6'd63;
    if (p.len() <= 5)
      for (int k = 0; k < 36; k++)
        if (morse_tab[k] == p) d = 6'(k);
    e = (d == 6'd63);
  endtask

  task automatic press(input int len);
    key_in = 1'b1;
    repeat (len) @(posedge clk);
    #1 key_in = 1'b0;
  endtask

  task automatic idle(input int len);
    repeat (len) @(posedge clk);
    #1;
  endtask

  // Dot = under 2 units held, dash = over 2 units; gaps stay below 3 units
  task automatic play(input string p, input bit rnd);
    for (int i = 0; i < p.len(); i++) begin
      if (p[i] == "-") press(rnd ? int'($urandom_range(10, 30)) : 12);
      else             press(rnd ? int'($urandom_range(2, 7)) : 4);
      if (i != p.len() - 1) idle(rnd ? int'($urandom_range(3, 9)) : 4);
    end
  endtask

  task automatic expect_ev(input string tag, input logic [5:0] d, input logic [4:0] c,
                           input logic [2:0] w, input logic e);
    ev_t ev;
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      check({tag, "_dout"}, 32'(ev.dout), 32'(d));
      check({tag, "_code"}, 32'(ev.code), 32'(c));
      check({tag, "_width"}, 32'(ev.width), 32'(w));
      check({tag, "_err"}, 32'(ev.err), 32'(e));
      $display("%s: dout=%0d code=%b width=%0d err=%0b", tag, ev.dout, ev.code, ev.width, ev.err);
    end
  endtask

  task automatic run_char(input string tag, input string p, input bit rnd);
    logic [5:0] d; logic [4:0] c; logic [2:0] w; logic e;
    model(p, d, c, w, e);
    play(p, rnd);
    idle(22);
    check({tag, "_count"}, 32'(evq.size()), 32'd1);
    expect_ev(tag, d, c, w, e);
    evq.delete();
  endtask

  initial begin
    string p, el;
    morse_tab = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                  "---..", "----.", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                  "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...",
                  "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    // Reset held with key toggling
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      key_in = ~key_in;
      @(posedge clk); #1;
      check("rst_outputs", {valid, err, dout, width, code}, 32'd0);
    end
    key_in = 1'b0;
    reset = 1'b1;
    idle(10);
    check("rst_no_valid", 32'(evq.size()), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);

    // Directed characters
    run_char("char_A", ".-", 1'b0);
    run_char("digit_0", "-----", 1'b0);
    run_char("overflow6", "------", 1'b0);
    run_char("invalid4", "----", 1'b0);

    // One-cycle glitch while released is ignored
    press(4); idle(6);
    key_in = 1'b1; idle(1); key_in = 1'b0;
    idle(22);
    check("glitch_count", 32'(evq.size()), 32'd1);
    expect_ev("glitch_E", 6'd14, 5'd0, 3'd1, 1'b0);
    evq.delete();

    // Press landing on the gap tick ends the character and starts a new one
    press(4); idle(12); press(4); idle(22);
    check("coincide_count", 32'(evq.size()), 32'd2);
    expect_ev("coincide_E1", 6'd14, 5'd0, 3'd1, 1'b0);
    expect_ev("coincide_E2", 6'd14, 5'd0, 3'd1, 1'b0);
    evq.delete();

    // Press one cycle before the gap tick joins the same character
    press(4); idle(11); press(4); idle(22);
    check("late_gap_count", 32'(evq.size()), 32'd1);
    expect_ev("late_gap_I", 6'd18, 5'd0, 3'd2, 1'b0);
    evq.delete();

    // Very long press still a dash
    press(40); idle(22);
    check("sat_count", 32'(evq.size()), 32'd1);
    expect_ev("sat_T", 6'd29, 5'd1, 3'd1, 1'b0);
    evq.delete();

    // Word gap: long release after E
    press(4); idle(45);
`ifdef MORSE_WORD_GAP_EN
    check("word_count", 32'(evq.size()), 32'd2);
    expect_ev("word_E", 6'd14, 5'd0, 3'd1, 1'b0);
    expect_ev("word_space", 6'd36, 5'd0, 3'd0, 1'b0);
`else
    check("word_count", 32'(evq.size()), 32'd1);
    expect_ev("word_E", 6'd14, 5'd0, 3'd1, 1'b0);
`endif
    evq.delete();
    idle(40);
    check("word_once", 32'(evq.size()), 32'd0);
    evq.delete();

    // Whole table with randomized timing
    for (int k = 0; k < 36; k++)
      run_char($sformatf("table%0d", k), morse_tab[k], 1'b1);

    // Random patterns of 1..6 elements
    for (int n = 0; n < 12; n++) begin
      p = "";
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        el = ($urandom_range(0, 1) == 1) ? "-" : ".";
        p = {p, el};
      end
      run_char($sformatf("rand%0d", n), p, 1'b1);
    end

    // Reset during a press discards the character
    key_in = 1'b1;
    idle(10);
    reset = 1'b0;
    idle(1);
    key_in = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(40);
    check("rst_mid_no_valid", 32'(evq.size()), 32'd0);
    check("rst_mid_dout", 32'(dout), 32'd0);
    check("rst_mid_width", 32'(width), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
